// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit register port: address/pointer/data decode,
// auto-incrementing register pointer, glitch-filtered SCL/SDA inputs.
module i2c_target_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A,
    parameter int         FILT_LEN   = 3
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    input  logic [7:0] rd_data,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [CW-1:0] cnt [2];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_d <= '1;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1  <= {sda_in, scl_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    logic scl, sda, scl_d, sda_d;
    logic scl_rise, scl_fall, start_c, stop_c;

    assign scl      = filt[0];
    assign sda      = filt[1];
    assign scl_d    = filt_d[0];
    assign sda_d    = filt_d[1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign start_c  = scl & scl_d & sda_d & ~sda;
    assign stop_c   = scl & scl_d & ~sda_d & sda;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       rw, rw_n;
    logic       load_pend, load_pend_n;
    logic       inc_pend, inc_pend_n;
    logic       sda_oe_n, wr_en_n;
    logic [7:0] wr_data_n, reg_addr_n;
    logic [7:0] byte_in;

    assign byte_in = {shift[6:0], sda};
    assign busy    = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rw        <= 1'b0;
            load_pend <= 1'b0;
            inc_pend  <= 1'b0;
            sda_oe    <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            reg_addr  <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            rw        <= rw_n;
            load_pend <= load_pend_n;
            inc_pend  <= inc_pend_n;
            sda_oe    <= sda_oe_n;
            wr_en     <= wr_en_n;
            wr_data   <= wr_data_n;
            reg_addr  <= reg_addr_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        rw_n        = rw;
        load_pend_n = load_pend;
        inc_pend_n  = 1'b0;
        sda_oe_n    = sda_oe;
        wr_en_n     = 1'b0;
        wr_data_n   = wr_data;
        reg_addr_n  = reg_addr;

        if (inc_pend)
            reg_addr_n = reg_addr + 8'd1;

        if (stop_c) begin
            state_n     = IDLE;
            sda_oe_n    = 1'b0;
            load_pend_n = 1'b0;
        end else if (start_c) begin
            state_n     = ADDR;
            bit_cnt_n   = '0;
            sda_oe_n    = 1'b0;
            load_pend_n = 1'b0;
        end else begin
            unique case (state)
                ADDR: if (scl_rise) begin
                    shift_n   = byte_in;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        // general call (address 0) is never acknowledged
                        if (shift[6:0] == SLAVE_ADDR && SLAVE_ADDR != 7'd0) begin
                            state_n = ADDR_ACK;
                            rw_n    = sda;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        if (state == ADDR_ACK && rw) begin
                            state_n  = RDATA;
                            shift_n  = rd_data;
                            sda_oe_n = ~rd_data[7];
                        end else if (state == ADDR_ACK) begin
                            state_n = REG;
                        end else begin
                            state_n = WDATA;
                        end
                    end
                end
                REG: if (scl_rise) begin
                    shift_n   = byte_in;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        reg_addr_n = byte_in;
                        state_n    = REG_ACK;
                    end
                end
                WDATA: if (scl_rise) begin
                    shift_n   = byte_in;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        wr_data_n  = byte_in;
                        wr_en_n    = 1'b1;
                        inc_pend_n = 1'b1;
                        state_n    = WDATA_ACK;
                    end
                end
                RDATA: if (scl_fall) begin
                    if (bit_cnt == 3'd7) begin
                        sda_oe_n   = 1'b0;
                        state_n    = RDATA_ACK;
                        reg_addr_n = reg_addr + 8'd1;
                    end else begin
                        shift_n   = {shift[6:0], 1'b0};
                        sda_oe_n  = ~shift[6];
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda)
                            state_n = IGNORE;
                        else
                            load_pend_n = 1'b1;
                    end else if (scl_fall && load_pend) begin
                        load_pend_n = 1'b0;
                        shift_n     = rd_data;
                        sda_oe_n    = ~rd_data[7];
                        bit_cnt_n   = '0;
                        state_n     = RDATA;
                    end
                end
                IDLE, IGNORE: ;
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
